// File: rtl/mem_and_wb.sv
// Memory-access and write-back stage: data memory, MEM/WB register and
// a post-reset sequencer that zeroes the data memory before accepting work.
module mem_and_wb #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      regwrite_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      mem_to_reg_in,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic [DATA_WIDTH-1:0]     write_data_mem_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_address_in,
    output logic                      regwrite,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic                      mem_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    unused_ok;

    // mem_read_in is informational only: the write-back mux follows mem_to_reg_in.
    assign unused_ok = mem_read_in;

    assign mem_addr  = alu_result_in[ADDR_WIDTH-1:0];
    assign load_data = mem[mem_addr];
    assign mem_busy  = (state == CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_waddr = mem_addr;
        mem_wdata = write_data_mem_in;
        unique case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == ADDR_WIDTH'(DEPTH - 1))
                    state_nxt = RUN;
            end
            RUN: begin
                mem_we = mem_write_in;
            end
            default: state_nxt = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite   <= 1'b0;
            write_data <= '0;
            write_addr <= '0;
        end else if (state == CLEAR) begin
            regwrite   <= 1'b0;
            write_data <= '0;
            write_addr <= '0;
        end else begin
            regwrite   <= regwrite_in;
            write_addr <= rd_address_in;
            write_data <= mem_to_reg_in ? load_data : alu_result_in;
        end
    end

endmodule

// File: tb/tb_mem_and_wb.sv
// Randomized self-checking bench for mem_and_wb against a flat-array
// reference of the data memory and a one-cycle write-back expectation.
module tb_mem_and_wb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       regwrite_in = 1'b0;
    logic       mem_read_in = 1'b0;
    logic       mem_write_in = 1'b0;
    logic       mem_to_reg_in = 1'b0;
    logic [7:0] alu_result_in = '0;
    logic [7:0] write_data_mem_in = '0;
    logic [2:0] rd_address_in = '0;
    logic       regwrite;
    logic [7:0] write_data;
    logic [2:0] write_addr;
    logic       mem_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_and_wb dut (
        .clk               (clk),
        .rst               (rst),
        .regwrite_in       (regwrite_in),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .mem_to_reg_in     (mem_to_reg_in),
        .alu_result_in     (alu_result_in),
        .write_data_mem_in (write_data_mem_in),
        .rd_address_in     (rd_address_in),
        .regwrite          (regwrite),
        .write_data        (write_data),
        .write_addr        (write_addr),
        .mem_busy          (mem_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bundle at the falling edge, check write-back one edge later.
    task automatic step(input logic rw, input logic mw, input logic m2r,
                        input logic [7:0] alu, input logic [7:0] wd,
                        input logic [2:0] rd, input string tag);
        logic [7:0] exp_data;
        regwrite_in       = rw;
        mem_write_in      = mw;
        mem_to_reg_in     = m2r;
        mem_read_in       = m2r;
        alu_result_in     = alu;
        write_data_mem_in = wd;
        rd_address_in     = rd;
        exp_data = m2r ? ref_mem[alu] : alu;
        if (mw) ref_mem[alu] = wd;
        @(posedge clk);
        #1;
        check({tag, ".regwrite"}, int'(regwrite), int'(rw));
        check({tag, ".addr"}, int'(write_addr), int'(rd));
        check({tag, ".data"}, int'(write_data), int'(exp_data));
        @(negedge clk);
    endtask

    // Count busy edges after release while a store + regwrite are driven.
    task automatic wait_clear(input string tag);
        int  n;
        bit  leak;
        n    = 0;
        leak = 1'b0;
        regwrite_in       = 1'b1;
        mem_write_in      = 1'b1;
        mem_to_reg_in     = 1'b0;
        alu_result_in     = 8'h20;
        write_data_mem_in = 8'hFF;
        rd_address_in     = 3'd6;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (regwrite !== 1'b0) leak = 1'b1;
            if (!mem_busy) break;
        end
        check({tag, ".busy_edges"}, n, 256);
        check({tag, ".rw_busy"}, int'(leak), 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        @(negedge clk);
        mem_write_in = 1'b0;
        regwrite_in  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        #1;
        check("rst.regwrite", int'(regwrite), 0);
        check("rst.data", int'(write_data), 0);
        check("rst.addr", int'(write_addr), 0);
        check("rst.busy", int'(mem_busy), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_clear("clr1");

        step(1, 0, 1, 8'h5A, 8'h00, 3'd4, "t1");
        step(1, 0, 1, 8'h20, 8'h00, 3'd1, "t4");
        step(1, 0, 0, 8'hA7, 8'h00, 3'd2, "t3");
        step(1, 0, 1, 8'hA7, 8'h00, 3'd3, "t3mem");
        step(0, 1, 0, 8'h10, 8'h3C, 3'd0, "t2st");
        step(1, 0, 1, 8'h10, 8'h00, 3'd5, "t2ld");
        step(0, 1, 0, 8'h40, 8'h11, 3'd0, "t6a");
        step(1, 1, 1, 8'h40, 8'h22, 3'd7, "t6b");
        step(1, 0, 1, 8'h40, 8'h00, 3'd7, "t6c");
        step(0, 0, 0, 8'h33, 8'h00, 3'd6, "rw0");

        for (int k = 0; k < 400; k++) begin
            logic [7:0] a;
            a = ($urandom % 2) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            step(1'($urandom), 1'($urandom), 1'($urandom), a,
                 8'($urandom), 3'($urandom), "rnd");
        end

        step(1, 1, 0, 8'hFF, 8'h99, 3'd5, "pre5");
        #2;
        rst = 1'b0;
        #1;
        check("t5.regwrite", int'(regwrite), 0);
        check("t5.data", int'(write_data), 0);
        check("t5.addr", int'(write_addr), 0);
        check("t5.busy", int'(mem_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        wait_clear("clr2");
        step(1, 0, 1, 8'hFF, 8'h00, 3'd1, "t5ld");
        step(1, 0, 1, 8'h20, 8'h00, 3'd2, "t5ld2");

        for (int k = 0; k < 200; k++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 31));
            step(1'($urandom), 1'($urandom), 1'($urandom), a,
                 8'($urandom), 3'($urandom), "rnd2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
